// File: rtl/apb_pkg.sv
// Shared APB types and default widths for the requester and register slaves.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 4;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_master_state_e;

endpackage

// File: rtl/apb_master.sv
// APB requester: one SETUP+ACCESS transfer per command, valid/ready response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_master_state_e state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Every output is a flop updated together with the state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout on the same cycle.
                    if (PREADY) begin
                        state     <= RESP;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= RESP;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        err_q     <= 1'b1;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master with a behavioural APB slave.
// Covers vectors, backpressure, back-to-back, reset abort and random traffic.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;

    apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave: PREADY low for wait_target ACCESS cycles, then high.
    logic [DW-1:0] smem [16] = '{default: '0};
    int wait_target = 0;
    int wait_cnt = 0;

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PRDATA = smem[PADDR];
            if (wait_cnt >= wait_target) begin
                PREADY = 1'b1;
            end else begin
                PREADY = 1'b0;
                wait_cnt++;
            end
        end else begin
            PREADY = 1'b0;
            PRDATA = '0;
            wait_cnt = 0;
        end
    end

    always @(posedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY && PWRITE)
            smem[PADDR] <= PWDATA;
    end

    // Reference: a flat memory image of what completed writes should leave.
    logic [DW-1:0] ref_mem [16] = '{default: '0};

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name,
                         input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input string tag,
                           input logic wr,
                           input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd,
                           input int waits,
                           input logic [DW-1:0] exp_rd,
                           input int exp_lat);
        int   lat;
        logic stable;
        wait_target = waits;
        @(negedge PCLK);
        check({tag, ".cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        if (wr) ref_mem[addr] = wd;
        @(negedge PCLK);
        check({tag, ".setup"}, {PSEL, PENABLE}, 2'b10);
        lat = 1;
        stable = 1'b1;
        while (!rsp_valid && lat < 60) begin
            @(negedge PCLK);
            lat++;
            if (!rsp_valid)
                stable &= PSEL && PENABLE && PADDR == addr &&
                          PWRITE == wr && (!wr || PWDATA == wd);
        end
        check({tag, ".latency"}, DW'(lat), DW'(exp_lat));
        check({tag, ".stable"}, stable, 1);
        check({tag, ".rdata"}, rsp_rdata, exp_rd);
        check({tag, ".err"}, rsp_err, 0);
        check({tag, ".psel_off"}, {PSEL, PENABLE}, 2'b00);
        @(negedge PCLK);
        check({tag, ".done"}, {rsp_valid, cmd_ready}, 2'b01);
        wait_target = 0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            waits;
        logic [DW-1:0] exp_rd;
        int            exp_lat;
    } vec_t;

    vec_t vecs [7];
    time  acc_t [4];

    initial begin
        int k;
        logic ok;
        logic [DW-1:0] exp_rd;
        logic wr;
        logic [AW-1:0] addr;
        int waits;

        vecs[0] = '{1'b1, 4'd2,  32'hDEADBEEF, 0, 32'h0,        3};
        vecs[1] = '{1'b0, 4'd2,  32'h0,        0, 32'hDEADBEEF, 3};
        vecs[2] = '{1'b1, 4'd1,  32'h12345678, 1, 32'h0,        4};
        vecs[3] = '{1'b0, 4'd1,  32'h0,        3, 32'h12345678, 6};
        vecs[4] = '{1'b1, 4'd15, 32'hA5A5A5A5, 2, 32'h0,        5};
        vecs[5] = '{1'b0, 4'd15, 32'h0,        0, 32'hA5A5A5A5, 3};
        vecs[6] = '{1'b0, 4'd0,  32'h0,        0, 32'h0,        3};

        // Reset state
        #12;
        check("rst.ctrl", {cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE},
              6'b100000);
        check("rst.paddr", PADDR, 0);
        check("rst.pwdata", PWDATA, 0);
        check("rst.rdata", rsp_rdata, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("idle.ctrl", {cmd_ready, rsp_valid, PSEL, PENABLE}, 4'b1000);

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr,
                    vecs[i].wd, vecs[i].waits, vecs[i].exp_rd, vecs[i].exp_lat);

        // Response backpressure: held response, commands refused
        rsp_ready = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd2;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        check("bp.rsp_seen", DW'(k < 20), 1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            ok &= rsp_valid && !cmd_ready && rsp_rdata == 32'hDEADBEEF;
            cmd_valid = (i == 1 || i == 2);
            cmd_write = 1'b1;
            cmd_addr  = 4'd2;
            cmd_wdata = 32'h0BADF00D;
        end
        check("bp.hold", ok, 1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        check("bp.released", {rsp_valid, cmd_ready}, 2'b01);
        ok = 1'b1;
        repeat (4) begin
            @(negedge PCLK);
            ok &= !PSEL;
        end
        check("bp.no_accept", ok, 1);
        run_txn("bp.readback", 1'b0, 4'd2, 0, 0, ref_mem[2], 3);

        // Back-to-back writes with cmd_valid and rsp_ready held high
        @(negedge PCLK);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_write = 1'b1;
            cmd_addr  = AW'(i);
            cmd_wdata = DW'((i + 1) * 32'h11);
            k = 0;
            while (!cmd_ready && k < 20) begin
                @(negedge PCLK);
                k++;
            end
            check($sformatf("b2b.accept%0d", i), DW'(k < 20), 1);
            @(posedge PCLK);
            acc_t[i] = $time;
            ref_mem[i] = DW'((i + 1) * 32'h11);
            #1;
        end
        cmd_valid = 1'b0;
        repeat (6) @(negedge PCLK);
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b.gap%0d", i), DW'(acc_t[i] - acc_t[i-1]), 40);
        for (int i = 0; i < 4; i++)
            run_txn($sformatf("b2b.rd%0d", i), 1'b0, AW'(i), 0, 0,
                    DW'((i + 1) * 32'h11), 3);

        // Reset asserted mid-ACCESS drops the transfer
        wait_target = 1000;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd7;
        cmd_wdata = 32'hBAD0BAD0;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("rstmid.access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        check("rstmid.drop", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
        @(negedge PCLK);
        PRESETn = 1'b1;
        wait_target = 0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            ok &= !rsp_valid && !PSEL;
        end
        check("rstmid.no_rsp", ok, 1);
        run_txn("rstmid.rd7", 1'b0, 4'd7, 0, 0, 32'h0, 3);

        // PREADY on the 16th ACCESS cycle completes normally
        run_txn("late_ready", 1'b0, 4'd1, 0, 15, ref_mem[1], 18);

`ifdef APB_MASTER_TIMEOUT_EN
        wait_target = 1000;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd3;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 60) begin
            @(negedge PCLK);
            k++;
        end
        check("tmo.latency", DW'(k), 18);
        check("tmo.err", rsp_err, 1);
        check("tmo.rdata", rsp_rdata, 0);
        check("tmo.psel", PSEL, 0);
        @(negedge PCLK);
        wait_target = 0;
`endif

        // Random traffic against the reference memory
        for (int i = 0; i < 24; i++) begin
            wr    = 1'($urandom);
            addr  = AW'($urandom);
            waits = int'($urandom_range(0, 3));
            exp_rd = wr ? '0 : ref_mem[addr];
            run_txn($sformatf("rnd%0d", i), wr, addr, $urandom, waits,
                    exp_rd, 3 + waits);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
